time_programmer: RTL and testbench
==================================

Name: time_programmer

Overview:
- Front-end "writer" for the egg-timer countdown path: turns raw push-buttons into BCD cook-time settings and a run enable.
- Drives the programmed-time inputs (seconds/tens_seconds/minutes/tens_minutes prog) and main_enable of the time counter.
- Consumes the counter's all-zero status to end a run and raise the alarm.
- Sits between board buttons and the time counter, in the same clk domain.

Parameters:
- DEBOUNCE_COUNT, 2, consecutive stable synchronized samples required before a button level is accepted (≥1).
- DB_WIDTH, 4, width of each debounce counter; must hold DEBOUNCE_COUNT-1.

Ports:
- clk  input  1  system clock (same clock as the time counter).
- reset  input  1  asynchronous, active-high reset.
- btn_select  input  1  raw button, async to clk; advances the edited digit.
- btn_up  input  1  raw button; increments the edited digit.
- btn_start  input  1  raw button; start/abort.
- count_zero  input  1  high when the time counter shows 00:00.
- seconds_prog  output  4  BCD 0-9.
- tens_seconds_prog  output  4  BCD 0-5.
- minutes_prog  output  4  BCD 0-9.
- tens_minutes_prog  output  4  BCD 0-9.
- main_enable  output  1  run enable to the time counter.
- editing  output  1  high in EDIT.
- edit_digit  output  2  selected digit: 0=seconds, 1=tens_seconds, 2=minutes, 3=tens_minutes.
- alarm  output  1  high in DONE.

Behaviour:
- Reset (async, any time, including mid-run or mid-edit):
  - all prog digits = 0, state = IDLE, edit_digit = 0.
  - main_enable, editing, alarm = 0.
  - synchronizers, debounce counters and stable levels = 0.
- Button path, per button:
  - 2-flop synchronizer.
  - Debounce counter clears while the synchronized level equals the stable level; otherwise it increments. When it reaches DEBOUNCE_COUNT-1 with the level still differing, the stable level updates and the counter clears.
  - Press pulse is registered and lasts exactly one cycle, on a 0->1 transition of the stable level only.
  - Latency: raw high first sampled at edge 0 -> press high for the cycle following edge DEBOUNCE_COUNT+2.
  - Glitches shorter than DEBOUNCE_COUNT cycles produce no press.
  - Holding a button produces a single press; release produces none.
- Simultaneous presses in one cycle: priority start > select > up; lower-priority presses are discarded.
- FSM states: IDLE, EDIT, RUN, DONE. All outputs are registered and change on the edge that takes the transition.
- IDLE:
  - select -> EDIT, edit_digit = 0.
  - start -> RUN only if any prog digit is nonzero; otherwise stay in IDLE.
  - up is ignored.
- EDIT (editing = 1):
  - up increments the selected digit mod its limit: seconds 9->0, tens_seconds 5->0, minutes 9->0, tens_minutes 9->0. Other digits are unchanged; there is no carry between digits.
  - select advances edit_digit 0->1->2->3->0.
  - start -> RUN if any digit is nonzero, else -> IDLE. edit_digit is retained on leaving EDIT.
- RUN (main_enable = 1):
  - count_zero is ignored in the first RUN cycle (counter load settling). From the second RUN cycle on, count_zero = 1 -> DONE.
  - start -> IDLE (abort). If count_zero and start are valid in the same cycle, DONE wins.
  - select and up are ignored.
  - prog digits are held constant throughout RUN.
- DONE (alarm = 1, main_enable = 0):
  - any press -> IDLE, alarm clears. prog digits are retained for re-run.
- Digits are never written outside EDIT or reset. Values are always legal BCD within their limits.

Test Plan:
1. Reset mid-RUN with digits 12:34 -> all digits 0, main_enable = 0, state IDLE, asynchronously (before the next clk edge).
2. DEBOUNCE_COUNT = 2: btn_up high for 1 cycle in EDIT -> no change. Held 20 cycles -> seconds_prog +1 exactly once, press one cycle wide, 4 edges after first sample.
3. EDIT, edit_digit = 1, 7 up presses from 0 -> tens_seconds_prog = 1 (0..5 wrap). Select x4 from 0 -> edit_digit back to 0.
4. Program 00:00 then start -> stays IDLE, main_enable = 0. Program 00:03, start -> main_enable = 1. count_zero pulsed in first RUN cycle -> ignored. count_zero later -> alarm = 1, main_enable = 0. Any press -> IDLE, digits still 00:03.
5. In IDLE, start and select pressed on the same cycle with nonzero digits -> RUN (select discarded). In RUN, start + count_zero on the same cycle -> DONE.
6. In RUN, press start -> IDLE, main_enable = 0 the next cycle. up/select presses during RUN -> digits unchanged.

Source files
------------

// File: rtl/time_programmer.sv
// Button front end and cook-time FSM for the egg timer. It debounces the raw buttons and drives the BCD
// program digits and the run enable. There is no backpressure. A press takes effect on the edge after the press pulse.
module time_programmer #(
   parameter int DEBOUNCE_COUNT = 2,
   parameter int DB_WIDTH       = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_select,
   input  logic       btn_up,
   input  logic       btn_start,
   input  logic       count_zero,
   output logic [3:0] seconds_prog,
   output logic [3:0] tens_seconds_prog,
   output logic [3:0] minutes_prog,
   output logic [3:0] tens_minutes_prog,
   output logic       main_enable,
   output logic       editing,
   output logic [1:0] edit_digit,
   output logic       alarm
);

   localparam logic [DB_WIDTH-1:0] DB_MAX = DB_WIDTH'(DEBOUNCE_COUNT - 1);

   typedef enum logic [1:0] {S_IDLE, S_EDIT, S_RUN, S_DONE} state_t;

   // Bit order in the button vectors: 0 = up, 1 = select, 2 = start
   logic [2:0]                w_raw;
   logic [2:0]                r_sync1;
   logic [2:0]                r_sync2;
   logic [2:0]                r_stable;
   logic [2:0]                r_stable_d;
   logic [2:0]                r_press;
   logic [2:0][DB_WIDTH-1:0]  r_db_cnt;

   assign w_raw = {btn_start, btn_select, btn_up};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1    <= '0;
         r_sync2    <= '0;
         r_stable   <= '0;
         r_stable_d <= '0;
         r_press    <= '0;
         r_db_cnt   <= '0;
      end else begin
         r_sync1    <= w_raw;
         r_sync2    <= r_sync1;
         r_stable_d <= r_stable;
         r_press    <= r_stable & ~r_stable_d;
         for (int i = 0; i < 3; i++) begin
            if (r_sync2[i] == r_stable[i]) begin
               r_db_cnt[i] <= '0;
            end else if (r_db_cnt[i] == DB_MAX) begin
               r_stable[i] <= r_sync2[i];
               r_db_cnt[i] <= '0;
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + DB_WIDTH'(1);
            end
         end
      end
   end

   // When presses coincide, start wins over select, and select wins over up
   logic w_start, w_sel, w_up, w_any_press;
   assign w_start     = r_press[2];
   assign w_sel       = r_press[1] & ~r_press[2];
   assign w_up        = r_press[0] & ~r_press[1] & ~r_press[2];
   assign w_any_press = |r_press;

   state_t           r_state, w_state_nxt;
   logic [3:0][3:0]  r_dig, w_dig_nxt;
   logic [1:0]       r_edit_digit, w_edit_digit_nxt;
   logic             r_run_first, w_run_first_nxt;
   logic             r_main_enable, r_editing, r_alarm;
   logic             w_any_nz;
   logic [3:0]       w_lim;

   assign w_any_nz = |r_dig;
   assign w_lim    = (r_edit_digit == 2'd1) ? 4'd5 : 4'd9;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_dig         <= '0;
         r_edit_digit  <= 2'd0;
         r_run_first   <= 1'b0;
         r_main_enable <= 1'b0;
         r_editing     <= 1'b0;
         r_alarm       <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_dig         <= w_dig_nxt;
         r_edit_digit  <= w_edit_digit_nxt;
         r_run_first   <= w_run_first_nxt;
         r_main_enable <= (w_state_nxt == S_RUN);
         r_editing     <= (w_state_nxt == S_EDIT);
         r_alarm       <= (w_state_nxt == S_DONE);
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_dig_nxt        = r_dig;
      w_edit_digit_nxt = r_edit_digit;
      w_run_first_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               if (w_any_nz) begin
                  w_state_nxt     = S_RUN;
                  w_run_first_nxt = 1'b1;
               end
            end else if (w_sel) begin
               w_state_nxt      = S_EDIT;
               w_edit_digit_nxt = 2'd0;
            end
         end
         S_EDIT: begin
            if (w_start) begin
               w_state_nxt     = w_any_nz ? S_RUN : S_IDLE;
               w_run_first_nxt = w_any_nz;
            end else if (w_sel) begin
               w_edit_digit_nxt = r_edit_digit + 2'd1;
            end else if (w_up) begin
               w_dig_nxt[r_edit_digit] = (r_dig[r_edit_digit] == w_lim) ? 4'd0
                                         : r_dig[r_edit_digit] + 4'd1;
            end
         end
         // During the first RUN cycle the counter is still loading, so its zero flag is ignored
         S_RUN: begin
            if (count_zero && !r_run_first) begin
               w_state_nxt = S_DONE;
            end else if (w_start) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_DONE: begin
            if (w_any_press) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign seconds_prog      = r_dig[0];
   assign tens_seconds_prog = r_dig[1];
   assign minutes_prog      = r_dig[2];
   assign tens_minutes_prog = r_dig[3];
   assign main_enable       = r_main_enable;
   assign editing           = r_editing;
   assign edit_digit        = r_edit_digit;
   assign alarm             = r_alarm;

endmodule

// File: tb/tb_time_programmer.sv
// Bench for time_programmer: vector table, timed corner sequences, and random presses against a reference model.
module tb_time_programmer;
   logic       clk = 1'b0;
   logic       reset, btn_select, btn_up, btn_start, count_zero;
   logic [3:0] seconds_prog, tens_seconds_prog, minutes_prog, tens_minutes_prog;
   logic       main_enable, editing, alarm;
   logic [1:0] edit_digit;

   time_programmer #(.DEBOUNCE_COUNT(2), .DB_WIDTH(4)) dut (
      .clk(clk), .reset(reset), .btn_select(btn_select), .btn_up(btn_up),
      .btn_start(btn_start), .count_zero(count_zero),
      .seconds_prog(seconds_prog), .tens_seconds_prog(tens_seconds_prog),
      .minutes_prog(minutes_prog), .tens_minutes_prog(tens_minutes_prog),
      .main_enable(main_enable), .editing(editing), .edit_digit(edit_digit), .alarm(alarm)
   );

   always #5 clk = ~clk;

   localparam logic [2:0] UP = 3'b001, SEL = 3'b010, STA = 3'b100;
   localparam int OP_PRESS = 0, OP_CZ = 1, OP_RST = 2;

   int checks = 0;
   int failures = 0;

   typedef struct {
      int          op;
      logic [2:0]  m;
      logic [20:0] exp;
   } vec_t;
   vec_t tbl[$];

   // Packed layout: {tens_min, min, tens_sec, sec, main_enable, editing, edit_digit, alarm}
   function automatic logic [20:0] pk(input logic [15:0] d, input logic en, input logic ed_f,
                                      input logic [1:0] ed, input logic al);
      return {d, en, ed_f, ed, al};
   endfunction

   function automatic logic [20:0] outs();
      return {tens_minutes_prog, minutes_prog, tens_seconds_prog, seconds_prog,
              main_enable, editing, edit_digit, alarm};
   endfunction

   task automatic check(input string name, input logic [20:0] exp);
      logic [20:0] got;
      got = outs();
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got dig=%h en=%b edit=%b ed=%0d al=%b, want dig=%h en=%b edit=%b ed=%0d al=%b",
                  name, got[20:5], got[4], got[3], got[2:1], got[0],
                  exp[20:5], exp[4], exp[3], exp[2:1], exp[0]);
      end
   endtask

   task automatic set_btn(input logic [2:0] m);
      btn_up     = m[0];
      btn_select = m[1];
      btn_start  = m[2];
   endtask

   // All sequences begin and end on a negedge.
   task automatic do_press(input logic [2:0] m);
      set_btn(m);
      repeat (6) @(negedge clk);
      set_btn(3'b000);
      repeat (8) @(negedge clk);
   endtask

   task automatic do_cz();
      count_zero = 1'b1;
      @(negedge clk);
      count_zero = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #2 reset = 1'b0;
      @(negedge clk);
   endtask

   // Transaction-level reference model. States: 0 idle, 1 edit, 2 run, 3 done.
   int ms;
   int md[4];
   int med;
   int lim[4] = '{10, 6, 10, 10};

   task automatic model_reset();
      ms = 0; med = 0;
      for (int k = 0; k < 4; k++) md[k] = 0;
   endtask

   task automatic model_press(input logic [2:0] m);
      bit st, se, u, nz;
      st = m[2];
      se = m[1] && !st;
      u  = m[0] && !m[1] && !st;
      nz = (md[0] + md[1] + md[2] + md[3]) != 0;
      case (ms)
         0: if (st) begin if (nz) ms = 2; end
            else if (se) begin ms = 1; med = 0; end
         1: if (st) ms = nz ? 2 : 0;
            else if (se) med = (med + 1) % 4;
            else if (u) md[med] = (md[med] + 1) % lim[med];
         2: if (st) ms = 0;
         default: ms = 0;
      endcase
   endtask

   function automatic logic [20:0] model_pack();
      return pk({4'(md[3]), 4'(md[2]), 4'(md[1]), 4'(md[0])},
                ms == 2, ms == 1, 2'(med), ms == 3);
   endfunction

   task automatic add(input int op, input logic [2:0] m, input logic [20:0] exp);
      vec_t v;
      v.op = op; v.m = m; v.exp = exp;
      tbl.push_back(v);
   endtask

   initial begin
      reset = 1'b1;
      count_zero = 1'b0;
      set_btn(3'b000);
      @(negedge clk);
      check("reset_state", pk(16'h0000, 0, 0, 0, 0));
      reset = 1'b0;
      @(negedge clk);

      // Vector table
      add(OP_PRESS, STA, pk(16'h0000, 0, 0, 0, 0));
      add(OP_PRESS, SEL, pk(16'h0000, 0, 1, 0, 0));
      add(OP_PRESS, STA, pk(16'h0000, 0, 0, 0, 0));
      add(OP_PRESS, SEL, pk(16'h0000, 0, 1, 0, 0));
      add(OP_PRESS, SEL, pk(16'h0000, 0, 1, 1, 0));
      add(OP_PRESS, UP,  pk(16'h0010, 0, 1, 1, 0));
      add(OP_PRESS, UP,  pk(16'h0020, 0, 1, 1, 0));
      add(OP_PRESS, UP,  pk(16'h0030, 0, 1, 1, 0));
      add(OP_PRESS, UP,  pk(16'h0040, 0, 1, 1, 0));
      add(OP_PRESS, UP,  pk(16'h0050, 0, 1, 1, 0));
      add(OP_PRESS, UP,  pk(16'h0000, 0, 1, 1, 0));
      add(OP_PRESS, UP,  pk(16'h0010, 0, 1, 1, 0));
      add(OP_PRESS, SEL, pk(16'h0010, 0, 1, 2, 0));
      add(OP_PRESS, SEL, pk(16'h0010, 0, 1, 3, 0));
      add(OP_PRESS, SEL, pk(16'h0010, 0, 1, 0, 0));
      add(OP_RST,   0,   pk(16'h0000, 0, 0, 0, 0));
      add(OP_PRESS, SEL, pk(16'h0000, 0, 1, 0, 0));
      add(OP_PRESS, UP,  pk(16'h0001, 0, 1, 0, 0));
      add(OP_PRESS, UP,  pk(16'h0002, 0, 1, 0, 0));
      add(OP_PRESS, UP,  pk(16'h0003, 0, 1, 0, 0));
      add(OP_PRESS, STA, pk(16'h0003, 1, 0, 0, 0));
      add(OP_CZ,    0,   pk(16'h0003, 0, 0, 0, 1));
      add(OP_PRESS, UP,  pk(16'h0003, 0, 0, 0, 0));
      add(OP_PRESS, STA, pk(16'h0003, 1, 0, 0, 0));
      add(OP_PRESS, SEL | UP, pk(16'h0003, 1, 0, 0, 0));
      add(OP_PRESS, UP,  pk(16'h0003, 1, 0, 0, 0));
      add(OP_PRESS, STA, pk(16'h0003, 0, 0, 0, 0));
      add(OP_PRESS, UP,  pk(16'h0003, 0, 0, 0, 0));
      add(OP_PRESS, SEL, pk(16'h0003, 0, 1, 0, 0));
      add(OP_PRESS, SEL, pk(16'h0003, 0, 1, 1, 0));
      add(OP_PRESS, STA, pk(16'h0003, 1, 0, 1, 0));
      add(OP_PRESS, STA, pk(16'h0003, 0, 0, 1, 0));
      add(OP_PRESS, SEL, pk(16'h0003, 0, 1, 0, 0));
      foreach (tbl[i]) begin
         case (tbl[i].op)
            OP_PRESS: do_press(tbl[i].m);
            OP_CZ:    do_cz();
            default:  do_reset();
         endcase
         check($sformatf("vec%0d", i), tbl[i].exp);
      end

      // A one-cycle glitch is ignored. A held press acts once, 5 edges after its first sample.
      do_reset();
      do_press(SEL);
      set_btn(UP);
      @(negedge clk);
      set_btn(3'b000);
      repeat (10) @(negedge clk);
      check("glitch_ignored", pk(16'h0000, 0, 1, 0, 0));
      set_btn(UP);
      repeat (5) @(negedge clk);
      check("latency_before", pk(16'h0000, 0, 1, 0, 0));
      @(negedge clk);
      check("latency_after", pk(16'h0001, 0, 1, 0, 0));
      repeat (14) @(negedge clk);
      set_btn(3'b000);
      repeat (10) @(negedge clk);
      check("hold_single", pk(16'h0001, 0, 1, 0, 0));

      // count_zero is ignored during the first RUN cycle
      do_press(UP);
      do_press(UP);
      set_btn(STA);
      repeat (5) @(negedge clk);
      check("run_before", pk(16'h0003, 0, 1, 0, 0));
      @(negedge clk);
      check("run_enter", pk(16'h0003, 1, 0, 0, 0));
      count_zero = 1'b1;
      @(negedge clk);
      count_zero = 1'b0;
      check("cz_first_ignored", pk(16'h0003, 1, 0, 0, 0));
      set_btn(3'b000);
      repeat (10) @(negedge clk);
      check("run_hold", pk(16'h0003, 1, 0, 0, 0));

      // When start and count_zero arrive on the same cycle, DONE wins
      set_btn(STA);
      repeat (5) @(negedge clk);
      count_zero = 1'b1;
      @(negedge clk);
      count_zero = 1'b0;
      check("cz_beats_start", pk(16'h0003, 0, 0, 0, 1));
      set_btn(3'b000);
      repeat (10) @(negedge clk);
      check("done_hold", pk(16'h0003, 0, 0, 0, 1));
      do_press(UP);
      check("done_exit", pk(16'h0003, 0, 0, 0, 0));

      // Start and select on the same cycle from IDLE enter RUN, then an abort
      do_press(STA | SEL);
      check("start_over_sel", pk(16'h0003, 1, 0, 0, 0));
      set_btn(STA);
      repeat (5) @(negedge clk);
      check("abort_before", pk(16'h0003, 1, 0, 0, 0));
      @(negedge clk);
      check("abort_after", pk(16'h0003, 0, 0, 0, 0));
      set_btn(3'b000);
      repeat (10) @(negedge clk);

      // Program 12:34, start a run, then assert reset asynchronously mid-run
      do_reset();
      do_press(SEL);
      repeat (4) do_press(UP);
      do_press(SEL);
      repeat (3) do_press(UP);
      do_press(SEL);
      repeat (2) do_press(UP);
      do_press(SEL);
      do_press(UP);
      do_press(STA);
      check("run_1234", pk(16'h1234, 1, 0, 3, 0));
      #2 reset = 1'b1;
      #1 check("async_reset", pk(16'h0000, 0, 0, 0, 0));
      #1 reset = 1'b0;
      @(negedge clk);
      check("post_reset", pk(16'h0000, 0, 0, 0, 0));

      // Random presses and zero-count events, checked against the model
      model_reset();
      for (int n = 0; n < 60; n++) begin
         int r;
         logic [2:0] m;
         r = $urandom_range(0, 9);
         if (ms == 2 && r < 3) begin
            do_cz();
            if (ms == 2) ms = 3;
         end else begin
            r = $urandom_range(0, 9);
            if (r < 5)      m = UP;
            else if (r < 8) m = SEL;
            else if (r < 9) m = STA;
            else            m = 3'($urandom_range(1, 7));
            do_press(m);
            model_press(m);
         end
         check($sformatf("rand%0d", n), model_pack());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
